// File: rtl/vc_output_arbiter.sv
// vc_output_arbiter: wormhole output stage over a bank of VC buffers.
// Round-robin grant, head-to-tail lock, per-VC downstream credit tracking.
module vc_output_arbiter #(
    parameter int NUM_VC  = 4,
    parameter int CREDITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_VC-1:0]    vc_empty,
    input  logic [64*NUM_VC-1:0] vc_data,
    output logic [NUM_VC-1:0]    vc_read_en,
    input  logic [NUM_VC-1:0]    credit_in,
    output logic                 out_valid,
    output logic [63:0]          out_flit,
    output logic [2:0]           out_vc,
    output logic                 busy,
    output logic                 error
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);
    localparam logic [1:0] T_HEAD = 2'b01;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state;
    logic [2:0]    rr_ptr;
    logic [2:0]    lock_vc;
    logic [CW-1:0] credit [NUM_VC];

    logic [7:0]  elig;
    logic [63:0] flit [8];
    logic        found;
    logic [2:0]  grant;
    logic [3:0]  idx;
    logic        pop;
    logic [2:0]  sel;
    logic [63:0] head;
    logic [1:0]  ftype;
    logic        fwd;
    logic        proto_err;
    logic        ovf;

    // Padded to 8 entries so any 3-bit VC index is a legal select.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 8; i++) flit[i] = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            elig[i] = !vc_empty[i] && (credit[i] != '0);
            flit[i] = vc_data[64*i +: 64];
        end
    end

    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            if (idx >= 4'(NUM_VC)) idx = idx - 4'(NUM_VC);
            if (!found && elig[idx[2:0]]) begin
                found = 1'b1;
                grant = idx[2:0];
            end
        end
    end

    // In IDLE only head (01) and single (11) flits are forwarded.
    always_comb begin
        if (state == LOCKED) begin
            sel = lock_vc;
            pop = elig[lock_vc];
        end else begin
            sel = grant;
            pop = found;
        end
        head  = flit[sel];
        ftype = head[63:62];
        fwd   = pop && ((state == LOCKED) || ftype[0]);
        proto_err = pop && ((state == LOCKED) ? (ftype == T_HEAD)
                                              : !ftype[0]);
        for (int i = 0; i < NUM_VC; i++)
            vc_read_en[i] = pop && !reset && (sel == 3'(i));
    end

    always_comb begin
        ovf = 1'b0;
        for (int i = 0; i < NUM_VC; i++)
            if (credit_in[i] && !(fwd && sel == 3'(i))
                && credit[i] == CMAX)
                ovf = 1'b1;
    end

    function automatic logic [2:0] nxt(input logic [2:0] v);
        return (v == 3'(NUM_VC - 1)) ? 3'd0 : v + 3'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lock_vc   <= '0;
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_vc    <= '0;
            error     <= 1'b0;
            for (int i = 0; i < NUM_VC; i++) credit[i] <= CMAX;
        end else begin
            out_valid <= fwd;
            error     <= proto_err | ovf;
            if (fwd) begin
                out_flit <= head;
                out_vc   <= sel;
            end
            if (pop) begin
                if (state == IDLE) begin
                    if (ftype == T_HEAD) begin
                        state   <= LOCKED;
                        lock_vc <= sel;
                    end else begin
                        rr_ptr <= nxt(sel);
                    end
                end else if (ftype[1]) begin
                    state  <= IDLE;
                    rr_ptr <= nxt(sel);
                end
            end
            for (int i = 0; i < NUM_VC; i++) begin
                if (credit_in[i] && !(fwd && sel == 3'(i))) begin
                    if (credit[i] != CMAX) credit[i] <= credit[i] + 1'b1;
                end else if (!credit_in[i] && fwd && sel == 3'(i)) begin
                    credit[i] <= credit[i] - 1'b1;
                end
            end
        end
    end

    assign busy = (state == LOCKED);

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Directed bench for vc_output_arbiter with a queue model of the VC buffers.
// Instance a uses CREDITS=32, instance b uses CREDITS=2 for credit stalls.
module tb_vc_output_arbiter;

    localparam int NV = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NV-1:0]    vc_empty, vc_read_en, credit_in;
    logic [64*NV-1:0] vc_data;
    logic             out_valid, busy, error;
    logic [63:0]      out_flit;
    logic [2:0]       out_vc;

    logic [NV-1:0]    b_vc_empty, b_vc_read_en, b_credit_in;
    logic [64*NV-1:0] b_vc_data;
    logic             b_out_valid, b_busy, b_error;
    logic [63:0]      b_out_flit;
    logic [2:0]       b_out_vc;

    logic [63:0] mem [NV][16];
    int          rp [NV];
    int          wp [NV];
    logic [63:0] bq [4];
    int          b_ptr, b_n;
    logic [NV-1:0] rd_a, rd_b;
    int passed = 0, total = 0, fails = 0;

    vc_output_arbiter #(.NUM_VC(NV), .CREDITS(32)) u_a (
        .clk(clk), .reset(reset), .vc_empty(vc_empty), .vc_data(vc_data),
        .vc_read_en(vc_read_en), .credit_in(credit_in),
        .out_valid(out_valid), .out_flit(out_flit), .out_vc(out_vc),
        .busy(busy), .error(error));

    vc_output_arbiter #(.NUM_VC(NV), .CREDITS(2)) u_b (
        .clk(clk), .reset(reset), .vc_empty(b_vc_empty),
        .vc_data(b_vc_data), .vc_read_en(b_vc_read_en),
        .credit_in(b_credit_in), .out_valid(b_out_valid),
        .out_flit(b_out_flit), .out_vc(b_out_vc), .busy(b_busy),
        .error(b_error));

    always_comb begin
        for (int i = 0; i < NV; i++) begin
            vc_empty[i] = (rp[i] == wp[i]);
            vc_data[64*i +: 64] = mem[i][rp[i] % 16];
        end
        b_vc_empty = {b_ptr >= b_n, 3'b111};
        b_vc_data = '0;
        b_vc_data[255:192] = bq[b_ptr % 4];
    end

    function automatic logic [63:0] f(input logic [1:0] t, input int pl);
        return {t, 62'(pl)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int v, input logic [1:0] t, input int pl);
        mem[v][wp[v] % 16] = f(t, pl);
        wp[v]++;
    endtask

    task automatic flush();
        for (int i = 0; i < NV; i++) begin
            rp[i] = 0;
            wp[i] = 0;
        end
        b_ptr = 0;
        b_n   = 0;
    endtask

    // Read enables sampled at negedge; buffers pop just after the edge.
    task automatic cyc();
        @(negedge clk);
        rd_a = vc_read_en;
        rd_b = b_vc_read_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++)
            if (rd_a[i] && rp[i] != wp[i]) rp[i]++;
        if (rd_b[3]) b_ptr++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int v, j;
        logic [1:0] t;
        reset = 1'b1;
        credit_in = '0;
        b_credit_in = '0;
        flush();
        cyc();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_flit", out_flit, 64'd0);
        chk("rst_vc", 64'(out_vc), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(error), 64'd0);
        chk("rst_b_valid", 64'(b_out_valid), 64'd0);

        push(0, 2'b01, 16); push(0, 2'b00, 17);
        push(0, 2'b00, 18); push(0, 2'b10, 19);
        cyc();
        chk("rst_rd", 64'(rd_a), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            t = (k == 0) ? 2'b01 : (k == 3) ? 2'b10 : 2'b00;
            cyc();
            chk("t1_rd", 64'(rd_a), 64'b0001);
            chk("t1_valid", 64'(out_valid), 64'd1);
            chk("t1_flit", out_flit, f(t, 16 + k));
            chk("t1_vc", 64'(out_vc), 64'd0);
            chk("t1_busy", 64'(busy), (k < 3) ? 64'd1 : 64'd0);
        end
        cyc();
        chk("t1_idle_rd", 64'(rd_a), 64'd0);
        chk("t1_idle_valid", 64'(out_valid), 64'd0);
        chk("t1_credit0", 64'(u_a.credit[0]), 64'd28);

        do_reset();
        for (int p = 0; p < 3; p++) begin
            t = (p == 0) ? 2'b01 : (p == 2) ? 2'b10 : 2'b00;
            push(1, t, 32 + p);
            push(2, t, 48 + p);
        end
        for (int k = 0; k < 6; k++) begin
            v = (k < 3) ? 1 : 2;
            j = k % 3;
            t = (j == 0) ? 2'b01 : (j == 2) ? 2'b10 : 2'b00;
            cyc();
            chk("t2_rd", 64'(rd_a), 64'd1 << v);
            chk("t2_valid", 64'(out_valid), 64'd1);
            chk("t2_vc", 64'(out_vc), 64'(v));
            chk("t2_flit", out_flit, f(t, 16 * (v + 1) + j));
            chk("t2_busy", 64'(busy), (j != 2) ? 64'd1 : 64'd0);
        end

        do_reset();
        for (int i = 0; i < NV; i++) begin
            push(i, 2'b11, 64 + i);
            push(i, 2'b11, 72 + i);
        end
        for (int k = 0; k < 8; k++) begin
            v = k % 4;
            cyc();
            chk("t4_rd", 64'(rd_a), 64'd1 << v);
            chk("t4_vc", 64'(out_vc), 64'(v));
            chk("t4_flit", out_flit, f(2'b11, (k < 4) ? 64 + v : 72 + v));
            chk("t4_valid", 64'(out_valid), 64'd1);
            chk("t4_busy", 64'(busy), 64'd0);
        end

        push(0, 2'b00, 80);
        cyc();
        chk("t5_rd", 64'(rd_a), 64'b0001);
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_err", 64'(error), 64'd1);
        cyc();
        chk("t5_err_clr", 64'(error), 64'd0);
        chk("t5_rd_idle", 64'(rd_a), 64'd0);
        chk("t5_credit0", 64'(u_a.credit[0]), 64'd30);

        push(2, 2'b01, 96); push(2, 2'b00, 97);
        push(2, 2'b00, 98); push(2, 2'b10, 99);
        cyc();
        chk("t6_rd", 64'(rd_a), 64'b0100);
        chk("t6_vc", 64'(out_vc), 64'd2);
        cyc();
        chk("t6_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_mid_valid", 64'(out_valid), 64'd0);
        chk("t6_mid_flit", out_flit, 64'd0);
        chk("t6_mid_vc", 64'(out_vc), 64'd0);
        chk("t6_mid_busy", 64'(busy), 64'd0);
        chk("t6_mid_rd", 64'(vc_read_en), 64'd0);
        flush();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < NV; i++)
            chk("t6_credit", 64'(u_a.credit[i]), 64'd32);
        credit_in = 4'b0010;
        cyc();
        credit_in = '0;
        chk("t6_ovf_err", 64'(error), 64'd1);
        chk("t6_ovf_cnt", 64'(u_a.credit[1]), 64'd32);
        cyc();
        chk("t6_ovf_clr", 64'(error), 64'd0);

        push(0, 2'b01, 112); push(0, 2'b01, 113); push(0, 2'b10, 114);
        cyc();
        chk("t7_head_busy", 64'(busy), 64'd1);
        cyc();
        chk("t7_rd", 64'(rd_a), 64'b0001);
        chk("t7_flit", out_flit, f(2'b01, 113));
        chk("t7_err", 64'(error), 64'd1);
        chk("t7_locked", 64'(busy), 64'd1);
        cyc();
        chk("t7_tail_err", 64'(error), 64'd0);
        chk("t7_tail_busy", 64'(busy), 64'd0);

        do_reset();
        bq[0] = f(2'b01, 128); bq[1] = f(2'b00, 129);
        bq[2] = f(2'b00, 130); bq[3] = f(2'b10, 131);
        b_n = 4;
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("t3_rd", 64'(rd_b), 64'b1000);
            chk("t3_flit", b_out_flit, bq[k]);
            chk("t3_vc", 64'(b_out_vc), 64'd3);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("t3_stall_rd", 64'(rd_b), 64'd0);
            chk("t3_stall_valid", 64'(b_out_valid), 64'd0);
            chk("t3_stall_busy", 64'(b_busy), 64'd1);
        end
        b_credit_in = 4'b1000;
        cyc();
        b_credit_in = '0;
        chk("t3_cred_rd", 64'(rd_b), 64'd0);
        cyc();
        chk("t3_one_rd", 64'(rd_b), 64'b1000);
        chk("t3_one_valid", 64'(b_out_valid), 64'd1);
        chk("t3_one_flit", b_out_flit, f(2'b00, 130));
        cyc();
        chk("t3_again_rd", 64'(rd_b), 64'd0);
        chk("t3_again_valid", 64'(b_out_valid), 64'd0);
        chk("t3_again_busy", 64'(b_busy), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
